sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 30 +++
 rtl/sram_arbiter_if.sv | 32 +++
 rtl/sram_rr_arb.sv | 25 ++
 rtl/sram_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared widths, FSM encoding and request record for the two-master SRAM arbiter.
package sram_arb_pkg;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 8;
  localparam int NUM_REQ = 2;
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_CLEAR  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] wdata;
  } arb_req_t;

  function automatic logic [IDX_W-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (oh[i]) idx = IDX_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Master request/response bus, clear handshake and SRAM port of the arbiter.
interface sram_arbiter_if;
  import sram_arb_pkg::*;

  logic              m0_req,    m1_req;
  logic              m0_we,     m1_we;
  logic [ADDR_W-1:0] m0_add,    m1_add;
  logic [DATA_W-1:0] m0_wdata,  m1_wdata;
  logic              m0_gnt,    m1_gnt;
  logic              m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata,  m1_rdata;
  logic              clr_req,   clr_done;
  logic              sram_cs, sram_rd, sram_wr, sram_res;
  logic [ADDR_W-1:0] sram_add;
  logic [DATA_W-1:0] sram_datain;
  logic [DATA_W-1:0] sram_datao;

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_add, m1_add, m0_wdata, m1_wdata,
    output clr_req, sram_datao,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, clr_done,
    input  sram_cs, sram_rd, sram_wr, sram_res, sram_add, sram_datain
  );

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_add, m1_add, m0_wdata, m1_wdata,
    input  clr_req, sram_datao,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, clr_done,
    output sram_cs, sram_rd, sram_wr, sram_res, sram_add, sram_datain
  );

endinterface

// File: rtl/sram_rr_arb.sv
// Round-robin select: the requester just after the last winner has top priority.
module sram_rr_arb
  import sram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic [IDX_W-1:0] idx;

  // Walk from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    gnt_o = '0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last_i) + k) % NUM_REQ);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter for a 16x8 synchronous SRAM with a one-cycle whole-array clear.
module sram_arbiter
  import sram_arb_pkg::*;
(
  input  logic         clk,
  input  logic         res,
  sram_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] ACCESS = ST_ACCESS;
  localparam logic [1:0] RDWAIT = ST_RDWAIT;
  localparam logic [1:0] CLEAR  = ST_CLEAR;

  logic [NUM_REQ-1:0] req_v;
  arb_req_t [NUM_REQ-1:0] mreq;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [IDX_W-1:0]   win_idx;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic clr_done_q, clr_done_d;
  logic cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, sres_q, sres_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [DATA_W-1:0] din_q, din_d;

  assign req_v   = {bus.m1_req, bus.m0_req};
  assign mreq[0] = {bus.m0_we, bus.m0_add, bus.m0_wdata};
  assign mreq[1] = {bus.m1_we, bus.m1_add, bus.m1_wdata};

  sram_rr_arb u_rr (
    .req_i  (req_v),
    .last_i (last_q),
    .gnt_o  (rr_gnt)
  );

  assign win_idx = oh2idx(rr_gnt);

  // Every strobe defaults low, so each one is a single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    clr_done_d = 1'b0;
    cs_d       = 1'b0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    sres_d     = 1'b0;
    add_d      = '0;
    din_d      = '0;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d    = CLEAR;
          cs_d       = 1'b1;
          sres_d     = 1'b1;
          clr_done_d = 1'b1;
        end else if (|req_v) begin
          state_d = ACCESS;
          win_d   = win_idx;
          last_d  = win_idx;
          gnt_d   = rr_gnt;
          cs_d    = 1'b1;
          add_d   = mreq[win_idx].add;
          din_d   = mreq[win_idx].wdata;
          wr_d    = mreq[win_idx].we;
          rd_d    = ~mreq[win_idx].we;
        end
      end
      ACCESS: state_d = rd_q ? RDWAIT : IDLE;
      RDWAIT: begin
        // SRAM output register holds the word addressed during ACCESS.
        rdata_d[win_q]  = bus.sram_datao;
        rvalid_d[win_q] = 1'b1;
        state_d         = IDLE;
      end
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      win_q      <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      clr_done_q <= 1'b0;
      cs_q       <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      sres_q     <= 1'b0;
      add_q      <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      clr_done_q <= clr_done_d;
      cs_q       <= cs_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      sres_q     <= sres_d;
      add_q      <= add_d;
      din_q      <= din_d;
    end
  end

  assign bus.m0_gnt      = gnt_q[0];
  assign bus.m1_gnt      = gnt_q[1];
  assign bus.m0_rvalid   = rvalid_q[0];
  assign bus.m1_rvalid   = rvalid_q[1];
  assign bus.m0_rdata    = rdata_q[0];
  assign bus.m1_rdata    = rdata_q[1];
  assign bus.clr_done    = clr_done_q;
  assign bus.sram_cs     = cs_q;
  assign bus.sram_rd     = rd_q;
  assign bus.sram_wr     = wr_q;
  assign bus.sram_res    = sres_q;
  assign bus.sram_add    = add_q;
  assign bus.sram_datain = din_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural 16x8 synchronous SRAM.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int K_GNT = 0;
  localparam int K_RV  = 1;
  localparam int K_CLR = 2;

  typedef struct {
    int         kind;
    int         m;
    logic       we;
    logic [3:0] add;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if bus ();

  sram_arbiter dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (bus.sram_cs && bus.sram_res) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (bus.sram_cs && bus.sram_wr) begin
      mem[bus.sram_add] <= bus.sram_datain;
    end
    if (bus.sram_cs && bus.sram_rd) bus.sram_datao <= mem[bus.sram_add];
  end

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   idle_cnt = 0;
  int   gnt_cyc [2];
  logic [7:0] mdl_rdata [2];
  logic rst_smp = 1'b0;
  bit   prev_evt = 1'b0;
  bit   done = 1'b0;
  bit   final_chk = 1'b0;

  function automatic void push(input int kind, input int m, input logic we,
                               input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    e.kind = kind; e.m = m; e.we = we; e.add = a; e.data = d;
    q.push_back(e);
  endfunction

  always @(posedge clk) rst_smp <= res;

  always @(negedge clk) begin
    logic [4:0] ev;
    logic [7:0] own, oth;
    exp_t e;
    int   ok, om, okind;
    cyc++;
    ev = {bus.clr_done, bus.m1_rvalid, bus.m0_rvalid, bus.m1_gnt, bus.m0_gnt};
    if (rst_smp) begin
      n_tests++;
      if ({ev, bus.m0_rdata, bus.m1_rdata, bus.sram_cs, bus.sram_rd, bus.sram_wr,
           bus.sram_res, bus.sram_add, bus.sram_datain} !== '0) begin
        n_fail++;
        $display("FAIL reset_zero: ev=%b rd0=%h rd1=%h cs=%b add=%h din=%h, required all zero",
                 ev, bus.m0_rdata, bus.m1_rdata, bus.sram_cs, bus.sram_add, bus.sram_datain);
      end
      mdl_rdata[0] = 8'h00; mdl_rdata[1] = 8'h00;
      prev_evt = 1'b0; idle_cnt = 0;
    end else begin
      n_tests++;
      if ($countones({bus.sram_rd, bus.sram_wr, bus.sram_res}) > 1 ||
          ((bus.sram_rd | bus.sram_wr | bus.sram_res) && !bus.sram_cs) ||
          $countones(ev) > 1) begin
        n_fail++;
        $display("FAIL sram_ctl @%0d: cs=%b rd=%b wr=%b res=%b ev=%b, required exclusive strobes under cs",
                 cyc, bus.sram_cs, bus.sram_rd, bus.sram_wr, bus.sram_res, ev);
      end
      if (prev_evt) begin
        n_tests++;
        if (bus.sram_cs || ev[0] || ev[1] || ev[4]) begin
          n_fail++;
          $display("FAIL one_cycle @%0d: cs=%b ev=%b, required cs=0 and no gnt/clr_done",
                   cyc, bus.sram_cs, ev);
        end
      end
      prev_evt = ev[0] | ev[1] | ev[4];
      if (ev != 5'b0) begin
        idle_cnt = 0;
        n_tests++;
        okind = ev[4] ? K_CLR : ((ev[0] | ev[1]) ? K_GNT : K_RV);
        om    = (!ev[4] && (ev[1] | ev[3])) ? 1 : 0;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected @%0d: ev=%b, required no event", cyc, ev);
        end else begin
          e = q.pop_front();
          if (okind != e.kind || om != e.m) begin
            n_fail++;
            $display("FAIL order @%0d: kind=%0d m=%0d, required kind=%0d m=%0d",
                     cyc, okind, om, e.kind, e.m);
          end else if (e.kind == K_GNT) begin
            gnt_cyc[om] = cyc;
            ok = (bus.sram_cs === 1'b1) && (bus.sram_add === e.add) &&
                 (bus.sram_wr === e.we) && (bus.sram_rd === !e.we) &&
                 (!e.we || bus.sram_datain === e.data);
            if (!ok) begin
              n_fail++;
              $display("FAIL gnt_m%0d @%0d: cs=%b wr=%b rd=%b add=%h din=%h, required cs=1 we=%b add=%h din=%h",
                       om, cyc, bus.sram_cs, bus.sram_wr, bus.sram_rd, bus.sram_add,
                       bus.sram_datain, e.we, e.add, e.data);
            end
          end else if (e.kind == K_RV) begin
            own = om ? bus.m1_rdata : bus.m0_rdata;
            oth = om ? bus.m0_rdata : bus.m1_rdata;
            if (own !== e.data || cyc != gnt_cyc[om] + 2 || oth !== mdl_rdata[1-om]) begin
              n_fail++;
              $display("FAIL rvalid_m%0d @%0d: rdata=%h lat=%0d other=%h, required rdata=%h lat=2 other=%h",
                       om, cyc, own, cyc - gnt_cyc[om], oth, e.data, mdl_rdata[1-om]);
            end
            mdl_rdata[om] = e.data;
          end else begin
            if (!(bus.sram_cs && bus.sram_res && !bus.sram_rd && !bus.sram_wr)) begin
              n_fail++;
              $display("FAIL clear @%0d: cs=%b res=%b rd=%b wr=%b, required cs=1 res=1 rd=0 wr=0",
                       cyc, bus.sram_cs, bus.sram_res, bus.sram_rd, bus.sram_wr);
            end
          end
        end
      end else if (bus.m0_req || bus.m1_req || bus.clr_req) begin
        idle_cnt++;
        if (idle_cnt == 20) begin
          n_tests++; n_fail++;
          $display("FAIL watchdog @%0d: 20 cycles with request pending, required a response", cyc);
        end
      end
    end
    if (done && !final_chk) begin
      final_chk = 1'b1;
      n_tests++;
      if (q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d expected events never seen, required 0", q.size());
      end
    end
  end

  task automatic set_req(input int m, input logic we, input logic [3:0] a, input logic [7:0] d);
    if (m == 0) begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_add = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_add = a; bus.m1_wdata = d;
    end
  endtask

  task automatic run();
    int n;
    n = 0;
    while ((bus.m0_req || bus.m1_req || bus.clr_req) && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.m0_gnt)   bus.m0_req  = 1'b0;
      if (bus.m1_gnt)   bus.m1_req  = 1'b0;
      if (bus.clr_done) bus.clr_req = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int cnt;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_add = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_add = 0; bus.m1_wdata = 0;
    bus.clr_req = 0;
    res = 1'b1;
    repeat (2) @(negedge clk);
    res = 1'b0;

    // m0 write then read-back; m1 blips a request while the arbiter is busy
    push(K_GNT, 0, 1'b1, 4'd1, 8'h02);
    set_req(0, 1'b1, 4'd1, 8'h02);
    run();
    push(K_GNT, 0, 1'b0, 4'd1, 8'h00);
    push(K_RV,  0, 1'b0, 4'd0, 8'h02);
    set_req(0, 1'b0, 4'd1, 8'h00);
    for (int n = 0; n < 20 && !bus.m0_gnt; n++) @(negedge clk);
    bus.m0_req = 1'b0;
    set_req(1, 1'b1, 4'd0, 8'hFF);
    @(negedge clk);
    bus.m1_req = 1'b0;
    repeat (4) @(negedge clk);

    // reset with non-zero rdata, pointer back to m0
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;

    push(K_GNT, 0, 1'b1, 4'd5,  8'h22);
    push(K_GNT, 1, 1'b1, 4'd13, 8'hE2);
    set_req(0, 1'b1, 4'd5,  8'h22);
    set_req(1, 1'b1, 4'd13, 8'hE2);
    run();
    push(K_GNT, 0, 1'b0, 4'd5,  8'h00);
    push(K_RV,  0, 1'b0, 4'd0,  8'h22);
    push(K_GNT, 1, 1'b0, 4'd13, 8'h00);
    push(K_RV,  1, 1'b0, 4'd0,  8'hE2);
    set_req(0, 1'b0, 4'd5,  8'h00);
    set_req(1, 1'b0, 4'd13, 8'h00);
    run();

    // continuous contention: strict alternation over 20 grants
    for (int i = 0; i < 20; i++)
      push(K_GNT, i % 2, 1'b1, (i % 2) ? 4'd3 : 4'd2, (i % 2) ? 8'hB0 : 8'hA0);
    set_req(0, 1'b1, 4'd2, 8'hA0);
    set_req(1, 1'b1, 4'd3, 8'hB0);
    cnt = 0;
    for (int n = 0; n < 100 && cnt < 20; n++) begin
      @(negedge clk);
      if (bus.m0_gnt || bus.m1_gnt) cnt++;
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    repeat (4) @(negedge clk);

    // clear beats a simultaneous m1 read, which then sees zero
    push(K_CLR, 0, 1'b0, 4'd0,  8'h00);
    push(K_GNT, 1, 1'b0, 4'd13, 8'h00);
    push(K_RV,  1, 1'b0, 4'd0,  8'h00);
    bus.clr_req = 1'b1;
    set_req(1, 1'b0, 4'd13, 8'h00);
    run();

    // m1 read aborted by reset in RDWAIT; SRAM contents survive
    push(K_GNT, 1, 1'b1, 4'd9, 8'h77);
    set_req(1, 1'b1, 4'd9, 8'h77);
    run();
    push(K_GNT, 1, 1'b0, 4'd9, 8'h00);
    set_req(1, 1'b0, 4'd9, 8'h00);
    for (int n = 0; n < 20 && !bus.m1_gnt; n++) @(negedge clk);
    bus.m1_req = 1'b0;
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    repeat (3) @(negedge clk);

    push(K_GNT, 0, 1'b1, 4'd7, 8'h5A);
    push(K_GNT, 1, 1'b1, 4'd8, 8'h6B);
    set_req(0, 1'b1, 4'd7, 8'h5A);
    set_req(1, 1'b1, 4'd8, 8'h6B);
    run();
    push(K_GNT, 0, 1'b0, 4'd9, 8'h00);
    push(K_RV,  0, 1'b0, 4'd0, 8'h77);
    push(K_GNT, 1, 1'b0, 4'd8, 8'h00);
    push(K_RV,  1, 1'b0, 4'd0, 8'h6B);
    set_req(0, 1'b0, 4'd9, 8'h00);
    set_req(1, 1'b0, 4'd8, 8'h00);
    run();

    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
